stepper_phase_driver: RTL and testbench

- Output-side counterpart of the push-button input path. The input path turns glitchy active-low physical signals into clean synchronous events; this block turns clean synchronous step commands into active-low stepper-coil drive signals.
- Accepts single-cycle step requests with a direction and sequences the four coil phases.
- Enforces a minimum step interval and buffers one early request.
- Sits between the debounced control logic and the motor driver pins.

---
 rtl/stepper_phase_driver.sv | 171 +++++++++++++++++
 tb/tb_stepper_phase_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_driver.sv
// Stepper phase driver: turns single-cycle step requests into active-low coil drive,
// holding each step MIN_STEP_CYCLES cycles and buffering one early request.
// Optional: define STEPPER_HALF_STEP_EN for the 8-entry half-step table.
module stepper_phase_driver #(
    parameter int MIN_STEP_CYCLES = 54000,
    parameter int CNT_W           = 16
) (
    input  logic             clock27MHz,
    input  logic             reset,
    input  logic             enable,
    input  logic             step_req,
    input  logic             dir,
    output logic             step_ack,
    output logic             busy,
    output logic             overrun,
    output logic [3:0]       coil_n,
    output logic [CNT_W-1:0] step_count
);

`ifdef STEPPER_HALF_STEP_EN
    localparam int PH_W = 3;
`else
    localparam int PH_W = 2;
`endif

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(MIN_STEP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pend_q, pend_d;
    logic              pend_dir_q, pend_dir_d;
    logic              overrun_q, overrun_d;
    logic [3:0]        coil_n_q, coil_n_d;
    logic              step_ack_q, step_ack_d;
    logic              busy_q, busy_d;
    logic              apply;
    logic              apply_dir;

    // Active-high coil pattern for a phase index.
    function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] idx);
        logic [3:0] pat;
        pat = 4'b0000;
`ifdef STEPPER_HALF_STEP_EN
        case (idx)
            3'd0: pat = 4'b1000;
            3'd1: pat = 4'b1100;
            3'd2: pat = 4'b0100;
            3'd3: pat = 4'b0110;
            3'd4: pat = 4'b0010;
            3'd5: pat = 4'b0011;
            3'd6: pat = 4'b0001;
            3'd7: pat = 4'b1001;
            default: pat = 4'b0000;
        endcase
`else
        case (idx)
            2'd0: pat = 4'b1100;
            2'd1: pat = 4'b0110;
            2'd2: pat = 4'b0011;
            2'd3: pat = 4'b1001;
            default: pat = 4'b0000;
        endcase
`endif
        return pat;
    endfunction

    always_ff @(posedge clock27MHz) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            phase_q    <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
            overrun_q  <= 1'b0;
            coil_n_q   <= 4'b1111;
            step_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            overrun_q  <= overrun_d;
            coil_n_q   <= coil_n_d;
            step_ack_q <= step_ack_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state: decides whether a step is applied this cycle and manages the pending slot.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        overrun_d  = overrun_q;
        apply      = 1'b0;
        apply_dir  = dir;
        if (!enable) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_req) begin
                        apply     = 1'b1;
                        apply_dir = dir;
                    end
                end
                HOLD: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                        if (step_req) begin
                            if (!pend_q) begin
                                pend_d     = 1'b1;
                                pend_dir_d = dir;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else if (pend_q) begin
                        // Terminal cycle: the buffered step goes first, a fresh request refills the slot.
                        apply      = 1'b1;
                        apply_dir  = pend_dir_q;
                        pend_d     = step_req;
                        pend_dir_d = dir;
                    end else if (step_req) begin
                        apply     = 1'b1;
                        apply_dir = dir;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (apply) begin
                state_d = HOLD;
                hold_d  = HOLD_RELOAD;
            end
        end
    end

    always_comb begin
        phase_d    = phase_q;
        count_d    = count_q;
        step_ack_d = apply;
        busy_d     = (state_d == HOLD);
        if (apply) begin
            phase_d = apply_dir ? phase_q + 1'b1 : phase_q - 1'b1;
            count_d = apply_dir ? count_q + 1'b1 : count_q - 1'b1;
        end
        coil_n_d = enable ? ~phase_pattern(phase_d) : 4'b1111;
    end

    assign step_ack   = step_ack_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign coil_n     = coil_n_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Bench for stepper_phase_driver with MIN_STEP_CYCLES = 4: directed vector table,
// hand-written corner sequences, and random stimulus against a timing-level model.
module tb_stepper_phase_driver;

    localparam int MIN = 4;
`ifdef STEPPER_HALF_STEP_EN
    localparam int NPH = 8;
    localparam logic [3:0] PH1_COIL = 4'b0011;
`else
    localparam int NPH = 4;
    localparam logic [3:0] PH1_COIL = 4'b1001;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        step_req = 1'b0;
    logic        dir = 1'b0;
    logic        step_ack;
    logic        busy;
    logic        overrun;
    logic [3:0]  coil_n;
    logic [15:0] step_count;

    stepper_phase_driver #(.MIN_STEP_CYCLES(MIN), .CNT_W(16)) dut (
        .clock27MHz (clk),
        .reset      (reset),
        .enable     (enable),
        .step_req   (step_req),
        .dir        (dir),
        .step_ack   (step_ack),
        .busy       (busy),
        .overrun    (overrun),
        .coil_n     (coil_n),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: step timing expressed as "cycle of last applied step" arithmetic.
    int        cyc = 0;
    int        last_apply = 0;
    bit        active = 0;
    int        q[$];
    int        m_phase = 0;
    int        m_count = 0;
    bit        m_ovr = 0;
    bit        m_ack = 0;
    logic [3:0] m_coil = 4'hF;

    function automatic logic [3:0] pat(input int idx);
`ifdef STEPPER_HALF_STEP_EN
        case (idx)
            0: return 4'b1000; 1: return 4'b1100; 2: return 4'b0100; 3: return 4'b0110;
            4: return 4'b0010; 5: return 4'b0011; 6: return 4'b0001; default: return 4'b1001;
        endcase
`else
        case (idx)
            0: return 4'b1100; 1: return 4'b0110; 2: return 4'b0011; default: return 4'b1001;
        endcase
`endif
    endfunction

    task automatic model_apply(input int d);
        last_apply = cyc + 1;
        active     = 1;
        m_phase    = (m_phase + (d != 0 ? 1 : NPH - 1)) % NPH;
        m_count    = (m_count + (d != 0 ? 1 : 65535)) % 65536;
        m_ack      = 1;
    endtask

    task automatic model_edge(input bit r, input bit e, input bit rq, input bit d);
        bit terminal;
        m_ack = 0;
        if (r) begin
            m_phase = 0; m_count = 0; active = 0; q.delete(); m_ovr = 0; m_coil = 4'hF;
        end else if (!e) begin
            active = 0; q.delete(); m_coil = 4'hF;
        end else begin
            terminal = active && (cyc == last_apply + MIN - 1);
            if (!active || terminal) begin
                if (q.size() > 0) begin
                    model_apply(q.pop_front());
                    if (rq) q.push_back(int'(d));
                end else if (rq) begin
                    model_apply(int'(d));
                end else begin
                    active = 0;
                end
            end else if (rq) begin
                if (q.size() == 0) q.push_back(int'(d));
                else m_ovr = 1;
            end
            m_coil = ~pat(m_phase);
        end
        cyc++;
    endtask

    task automatic drive(input bit r, input bit e, input bit rq, input bit d);
        reset = r; enable = e; step_req = rq; dir = d;
        model_edge(r, e, rq, d);
        @(posedge clk);
        #1;
        chk("model coil_n", 32'(coil_n), 32'(m_coil));
        chk("model step_ack", 32'(step_ack), 32'(m_ack));
        chk("model busy", 32'(busy), 32'(active));
        chk("model overrun", 32'(overrun), 32'(m_ovr));
        chk("model step_count", 32'(step_count), 32'(m_count));
    endtask

    typedef struct {
        bit         r, e, rq, d;
        logic [3:0] coil;
        bit         ack, bsy, ovr;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[15];
    int   acks, busys;
    logic [3:0] seen[$];

    initial begin
        tv[0]  = '{1, 0, 0, 0, 4'hF, 0, 0, 0, 16'h0000};
        tv[1]  = '{1, 0, 0, 0, 4'hF, 0, 0, 0, 16'h0000};
        tv[2]  = '{0, 1, 0, 0, 4'h3, 0, 0, 0, 16'h0000};
        tv[3]  = '{0, 1, 1, 1, 4'h9, 1, 1, 0, 16'h0001};
        tv[4]  = '{0, 1, 0, 0, 4'h9, 0, 1, 0, 16'h0001};
        tv[5]  = '{0, 1, 0, 0, 4'h9, 0, 1, 0, 16'h0001};
        tv[6]  = '{0, 1, 0, 0, 4'h9, 0, 1, 0, 16'h0001};
        tv[7]  = '{0, 1, 0, 0, 4'h9, 0, 0, 0, 16'h0001};
        tv[8]  = '{0, 1, 1, 1, 4'hC, 1, 1, 0, 16'h0002};
        tv[9]  = '{0, 1, 0, 0, 4'hC, 0, 1, 0, 16'h0002};
        tv[10] = '{0, 1, 0, 0, 4'hC, 0, 1, 0, 16'h0002};
        tv[11] = '{0, 1, 0, 0, 4'hC, 0, 1, 0, 16'h0002};
        tv[12] = '{0, 1, 0, 0, 4'hC, 0, 0, 0, 16'h0002};
        tv[13] = '{1, 1, 0, 0, 4'hF, 0, 0, 0, 16'h0000};
        tv[14] = '{0, 1, 1, 0, 4'h6, 1, 1, 0, 16'hFFFF};

`ifndef STEPPER_HALF_STEP_EN
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].r, tv[i].e, tv[i].rq, tv[i].d);
            chk($sformatf("vec%0d coil_n", i), 32'(coil_n), 32'(tv[i].coil));
            chk($sformatf("vec%0d step_ack", i), 32'(step_ack), 32'(tv[i].ack));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'(tv[i].ovr));
            chk($sformatf("vec%0d step_count", i), 32'(step_count), 32'(tv[i].cnt));
        end

        // Four forward steps spaced 6 cycles apart.
        drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 1, 0, 0);
        acks = 0; busys = 0; seen.delete();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) begin
                drive(0, 1, j == 0, 1);
                if (step_ack) begin acks++; seen.push_back(coil_n); end
                if (busy) busys++;
            end
        end
        chk("fwd4 acks", 32'(acks), 32'd4);
        chk("fwd4 busy cycles", 32'(busys), 32'd16);
        chk("fwd4 step_count", 32'(step_count), 32'd4);
        if (seen.size() == 4) begin
            chk("fwd4 coil0", 32'(seen[0]), 32'h9);
            chk("fwd4 coil1", 32'(seen[1]), 32'hC);
            chk("fwd4 coil2", 32'(seen[2]), 32'h6);
            chk("fwd4 coil3", 32'(seen[3]), 32'h3);
        end
`else
        // Eight forward half-steps from index 0.
        drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 1, 0, 0);
        acks = 0; seen.delete();
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 6; j++) begin
                drive(0, 1, j == 0, 1);
                if (step_ack) begin acks++; seen.push_back(coil_n); end
            end
        end
        chk("half8 acks", 32'(acks), 32'd8);
        chk("half8 step_count", 32'(step_count), 32'd8);
        if (seen.size() == 8) begin
            chk("half8 coil0", 32'(seen[0]), 32'h3);
            chk("half8 coil1", 32'(seen[1]), 32'hB);
            chk("half8 coil2", 32'(seen[2]), 32'h9);
            chk("half8 coil3", 32'(seen[3]), 32'hD);
            chk("half8 coil4", 32'(seen[4]), 32'hC);
            chk("half8 coil5", 32'(seen[5]), 32'hE);
            chk("half8 coil6", 32'(seen[6]), 32'h6);
            chk("half8 coil7", 32'(seen[7]), 32'h7);
        end
`endif

        // Requests at t, t+1, t+2: second buffered, third dropped.
        drive(1, 0, 0, 0); drive(0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 1, k <= 3, 1);
            chk($sformatf("burst ack obs%0d", k), 32'(step_ack), 32'((k == 1) || (k == 5)));
            chk($sformatf("burst busy obs%0d", k), 32'(busy), 32'(k <= 8));
        end
        chk("burst overrun", 32'(overrun), 32'd1);
        chk("burst step_count", 32'(step_count), 32'd2);

        // Enable dropped mid-hold with a pending request.
        drive(1, 0, 0, 0); drive(0, 1, 0, 0);
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 1);
        drive(0, 0, 0, 0);
        chk("disable coil_n", 32'(coil_n), 32'hF);
        chk("disable busy", 32'(busy), 32'd0);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0);
            if (step_ack) acks++;
            if (k == 0) chk("reenable coil_n", 32'(coil_n), 32'(PH1_COIL));
        end
        chk("disable no late ack", 32'(acks), 32'd0);
        chk("disable step_count", 32'(step_count), 32'd1);

        // Reset asserted mid-hold.
        drive(0, 1, 1, 0); drive(0, 1, 0, 0);
        drive(1, 1, 1, 1);
        chk("midreset coil_n", 32'(coil_n), 32'hF);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset step_ack", 32'(step_ack), 32'd0);
        chk("midreset overrun", 32'(overrun), 32'd0);
        chk("midreset step_count", 32'(step_count), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
